// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// Holds the run-state enum and the displayed-count range.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2
    } sw_state_t;

    localparam int VALUE_W   = 14;
    localparam int MAX_COUNT = 9999;

    function automatic logic [VALUE_W-1:0] count_inc(
        input logic [VALUE_W-1:0] v
    );
        return (v == VALUE_W'(MAX_COUNT)) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce, press pulse.
// A press pulse appears 2 + DEB_CYC + 1 cycles after raw goes high.
module btn_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // cnt tracks how long sync2 has disagreed with level
            if (sync2 != level) begin
                if (cnt == CNT_W'(DEB_CYC - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/clear controller with 0..9999 count.
// Define STOPWATCH_LAP_EN to build in the LAP state and lap button.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_HZ     = 10,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_btnRunStop,
    input  logic               i_btnClear,
    input  logic               i_btnLap,
    output logic [VALUE_W-1:0] o_value,
    output logic               o_running,
    output logic               o_tick
);

    localparam int DEBOUNCE_CYC = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int PSC_N = CLK_HZ / TICK_HZ;
    localparam int PSC_W = (PSC_N > 1) ? $clog2(PSC_N) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PSC_N - 1);

    logic               rs_ev;
    logic               clr_ev;
    logic               lap_ev;
    sw_state_t          state;
    sw_state_t          state_nxt;
    logic [VALUE_W-1:0] count;
    logic [VALUE_W-1:0] count_nxt;
    logic [VALUE_W-1:0] value_nxt;
    logic [PSC_W-1:0]   psc;
    logic [PSC_W-1:0]   psc_nxt;
    logic               tick_nxt;

    btn_debounce #(.DEB_CYC(DEBOUNCE_CYC)) u_rs (
        .clk   (i_clk),
        .reset (i_reset),
        .btn   (i_btnRunStop),
        .press (rs_ev)
    );

    btn_debounce #(.DEB_CYC(DEBOUNCE_CYC)) u_clr (
        .clk   (i_clk),
        .reset (i_reset),
        .btn   (i_btnClear),
        .press (clr_ev)
    );

`ifdef STOPWATCH_LAP_EN
    logic [VALUE_W-1:0] lap_q;
    logic [VALUE_W-1:0] lap_nxt;

    btn_debounce #(.DEB_CYC(DEBOUNCE_CYC)) u_lap (
        .clk   (i_clk),
        .reset (i_reset),
        .btn   (i_btnLap),
        .press (lap_ev)
    );
`else
    logic unused_lap;
    assign unused_lap = i_btnLap;
    assign lap_ev     = 1'b0;
`endif

    always_comb begin
        tick_nxt = (state != STOP) && (psc == PSC_MAX);
        psc_nxt  = psc + 1'b1;
        if (state == STOP || tick_nxt) begin
            psc_nxt = '0;
        end

        count_nxt = count;
        if (tick_nxt) begin
            count_nxt = count_inc(count);
        end else if (state == STOP && clr_ev) begin
            count_nxt = '0;
        end

        // runstop outranks lap when both arrive together
        state_nxt = state;
        case (state)
            STOP: begin
                if (rs_ev) state_nxt = RUN;
            end
            RUN: begin
                if (rs_ev)       state_nxt = STOP;
                else if (lap_ev) state_nxt = LAP;
            end
            LAP: begin
                if (rs_ev)       state_nxt = STOP;
                else if (lap_ev) state_nxt = RUN;
            end
            default: state_nxt = STOP;
        endcase
    end

`ifdef STOPWATCH_LAP_EN
    always_comb begin
        lap_nxt = lap_q;
        if (state_nxt == LAP && state != LAP) begin
            lap_nxt = count_nxt;
        end
        value_nxt = (state_nxt == LAP) ? lap_nxt : count_nxt;
    end
`else
    assign value_nxt = count_nxt;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= STOP;
            count     <= '0;
            psc       <= '0;
            o_value   <= '0;
            o_running <= 1'b0;
            o_tick    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_q     <= '0;
`endif
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            psc       <= psc_nxt;
            o_value   <= value_nxt;
            o_running <= (state_nxt != STOP);
            o_tick    <= tick_nxt;
`ifdef STOPWATCH_LAP_EN
            lap_q     <= lap_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, directed corners, random.
// Works with or without STOPWATCH_LAP_EN defined.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int P    = 10;
    localparam int DC   = 4;
    localparam int MAXC = 9999;

    logic        clk = 1'b0;
    logic        rst, b_rs, b_clr, b_lap;
    logic [13:0] value;
    logic        running, tick;
    logic        w_rst, w_rs;
    logic [13:0] w_value;
    logic        w_running, w_tick;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_MS(4)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_btnRunStop (b_rs),
        .i_btnClear   (b_clr),
        .i_btnLap     (b_lap),
        .o_value      (value),
        .o_running    (running),
        .o_tick       (tick)
    );

    // one tick per clock: lets the wrap be reached quickly
    stopwatch_ctrl #(
        .CLK_HZ(1000), .TICK_HZ(1000), .DEBOUNCE_MS(4)
    ) dut_w (
        .i_clk        (clk),
        .i_reset      (w_rst),
        .i_btnRunStop (w_rs),
        .i_btnClear   (1'b0),
        .i_btnLap     (1'b0),
        .o_value      (w_value),
        .o_running    (w_running),
        .o_tick       (w_tick)
    );

    // reference model: mode 0=stopped 1=running 2=lap view
    int       m_mode, m_count, m_lapv, m_phase;
    bit       m_tick;
    bit       m_sa[3], m_sb[3], m_lvl[3], m_lvlp[3], m_pls[3];
    bit [7:0] m_hist[3];
    int       m_hcnt[3];

    task automatic model_edge();
        bit raw[3];
        bit prs, pcl, plp;
        raw[0] = b_rs;
        raw[1] = b_clr;
        raw[2] = b_lap;
        prs = m_pls[0];
        pcl = m_pls[1];
        plp = LAP_EN && m_pls[2];
        if (rst) begin
            m_mode = 0; m_count = 0; m_lapv = 0;
            m_phase = 0; m_tick = 0;
            for (int b = 0; b < 3; b++) begin
                m_sa[b] = 0; m_sb[b] = 0; m_lvl[b] = 0;
                m_lvlp[b] = 0; m_pls[b] = 0;
                m_hist[b] = 0; m_hcnt[b] = 0;
            end
        end else begin
            m_tick = 0;
            if (m_mode != 0) begin
                m_phase++;
                if (m_phase % P == 0) begin
                    m_tick = 1;
                    m_count = (m_count == MAXC) ? 0 : m_count + 1;
                end
            end else begin
                m_phase = 0;
            end
            if (m_mode == 0 && pcl) m_count = 0;
            case (m_mode)
                0: if (prs) m_mode = 1;
                1: begin
                    if (prs) m_mode = 0;
                    else if (plp) begin
                        m_mode = 2;
                        m_lapv = m_count;
                    end
                end
                default: begin
                    if (prs)      m_mode = 0;
                    else if (plp) m_mode = 1;
                end
            endcase
            for (int b = 0; b < 3; b++) begin
                bit       np;
                bit [7:0] mask;
                mask = 8'((1 << DC) - 1);
                np = m_lvl[b] && !m_lvlp[b];
                m_lvlp[b] = m_lvl[b];
                m_hist[b] = {m_hist[b][6:0], m_sb[b]};
                if (m_hcnt[b] < DC) m_hcnt[b]++;
                if (m_hcnt[b] == DC &&
                    (m_hist[b] & mask) == (m_lvl[b] ? 8'd0 : mask)) begin
                    m_lvl[b] = !m_lvl[b];
                    m_hcnt[b] = 0;
                end
                m_sb[b] = m_sa[b];
                m_sa[b] = raw[b];
                m_pls[b] = np;
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)",
                     nm, act, req, $time);
        end
    endtask

    task automatic cyc();
        int exp_v;
        bit exp_r;
        model_edge();
        @(posedge clk);
        #1;
        exp_v = (m_mode == 2) ? m_lapv : m_count;
        exp_r = (m_mode != 0);
        n_chk++;
        if (value !== 14'(exp_v) || running !== exp_r ||
            tick !== m_tick) begin
            n_err++;
            $display("FAIL model: val/run/tick=%0d/%0d/%0d want %0d/%0d/%0d (t=%0t)",
                     value, running, tick, exp_v, exp_r, m_tick, $time);
        end
    endtask

    task automatic wait_val(input int v, input int bound, input string nm);
        int n = 0;
        while (int'(value) != v && n < bound) begin
            cyc();
            n++;
        end
        chk(nm, int'(value), v);
    endtask

    task automatic reset_run();
        rst = 1; cyc(); rst = 0;
        b_rs = 1; repeat (8) cyc();
        b_rs = 0; repeat (10) cyc();
    endtask

    typedef struct {
        bit rs;
        bit clr;
        bit lap;
        int w;
        bit run;
        int val;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n;
        tbl[0] = '{1, 0, 0, 25, 1, 2};
        tbl[1] = '{1, 0, 0, 10, 0, 3};
        tbl[2] = '{0, 1, 0, 10, 0, 0};
        tbl[3] = '{1, 1, 0, 35, 1, 3};
        tbl[4] = '{0, 1, 0, 10, 1, 5};
        tbl[5] = '{1, 0, 1, 10, 0, 6};
        tbl[6] = '{0, 0, 1, 10, 0, 6};

        rst = 1; b_rs = 0; b_clr = 0; b_lap = 0;
        w_rst = 1; w_rs = 0;
        cyc(); cyc();
        chk("rst_value", int'(value), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_tick", int'(tick), 0);
        rst = 0; w_rst = 0;

        // first press: event latency and tick cadence
        b_rs = 1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 6) chk("press_pre", int'(running), 0);
            if (i == 7) chk("press_run", int'(running), 1);
        end
        b_rs = 0;
        for (int i = 8; i < 28; i++) begin
            cyc();
            if (i == 16) chk("tick_pre", int'(tick), 0);
            if (i == 16) chk("val_pre", int'(value), 0);
            if (i == 17) chk("tick_1st", int'(tick), 1);
            if (i == 17) chk("val_1st", int'(value), 1);
            if (i == 27) chk("tick_2nd", int'(tick), 1);
            if (i == 27) chk("val_2nd", int'(value), 2);
        end

        // bouncing button never settles
        rst = 1; cyc(); rst = 0;
        for (int k = 0; k < 6; k++) begin
            b_rs = 1; cyc(); cyc();
            b_rs = 0; cyc(); cyc();
        end
        repeat (10) cyc();
        chk("bounce_run", int'(running), 0);

        // vector table
        rst = 1; cyc(); rst = 0;
        for (int i = 0; i < 7; i++) begin
            b_rs = tbl[i].rs; b_clr = tbl[i].clr; b_lap = tbl[i].lap;
            repeat (8) cyc();
            b_rs = 0; b_clr = 0; b_lap = 0;
            repeat (tbl[i].w) cyc();
            chk($sformatf("vec%0d_run", i), int'(running), tbl[i].run);
            chk($sformatf("vec%0d_val", i), int'(value), tbl[i].val);
        end

        // clear ignored in run, honoured in stop, clear+runstop
        reset_run();
        wait_val(37, 500, "reach_37");
        b_clr = 1; repeat (8) cyc();
        b_clr = 0; repeat (4) cyc();
        chk("clr_in_run", int'(value), 38);
        b_rs = 1; repeat (8) cyc();
        b_rs = 0; repeat (10) cyc();
        chk("stop_run", int'(running), 0);
        chk("stop_val", int'(value), 39);
        b_rs = 1; b_clr = 1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 7) chk("clrrs_run", int'(running), 1);
            if (i == 7) chk("clrrs_val", int'(value), 0);
        end
        b_rs = 0; b_clr = 0;
        repeat (10) cyc();
        chk("clrrs_tick", int'(value), 1);
        b_rs = 1; repeat (8) cyc();
        b_rs = 0; repeat (10) cyc();
        b_clr = 1; repeat (8) cyc();
        b_clr = 0; repeat (4) cyc();
        chk("clr_in_stop", int'(value), 0);

        // lap view freezes the display while counting continues
        reset_run();
        wait_val(25, 400, "reach_25");
        b_lap = 1; repeat (8) cyc();
        b_lap = 0; repeat (36) cyc();
        chk("lap_frozen4", int'(value), LAP_EN ? 25 : 29);
        b_lap = 1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 6) chk("lap_frozen5", int'(value), LAP_EN ? 25 : 30);
        end
        b_lap = 0;
        chk("lap_exit", int'(value), 30);
        chk("lap_exit_run", int'(running), 1);
        repeat (10) cyc();
        b_lap = 1; repeat (8) cyc();
        b_lap = 0; repeat (10) cyc();
        b_rs = 1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 6) chk("lap2_view", int'(value), LAP_EN ? 32 : 33);
        end
        b_rs = 0;
        chk("lap_stop_val", int'(value), 33);
        chk("lap_stop_run", int'(running), 0);

        // reset mid-run, then reset mid-press
        reset_run();
        wait_val(412, 5000, "reach_412");
        rst = 1; cyc(); rst = 0;
        chk("midrst_val", int'(value), 0);
        chk("midrst_run", int'(running), 0);
        chk("midrst_tick", int'(tick), 0);
        b_rs = 1; repeat (4) cyc();
        rst = 1; cyc(); rst = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 6) chk("rstpress_pre", int'(running), 0);
            if (i == 7) chk("rstpress_run", int'(running), 1);
        end
        b_rs = 0;

        // 9998 -> 9999 -> 0 on the fast-tick instance
        w_rs = 1; repeat (8) cyc();
        w_rs = 0;
        n = 0;
        while (int'(w_value) != 9998 && n < 10100) begin
            cyc();
            n++;
        end
        chk("wrap_reach", int'(w_value), 9998);
        chk("wrap_cycles", n, 9998);
        cyc();
        chk("wrap_9999", int'(w_value), 9999);
        cyc();
        chk("wrap_zero", int'(w_value), 0);
        chk("wrap_tick", int'(w_tick), 1);
        chk("wrap_run", int'(w_running), 1);

        // random presses, bounces and combinations
        rst = 1; cyc(); rst = 0;
        repeat (80) begin
            int mask;
            int hold;
            bit bnc;
            mask = $urandom_range(0, 7);
            hold = $urandom_range(1, 14);
            bnc  = ($urandom_range(0, 3) == 0);
            for (int h = 0; h < hold; h++) begin
                b_rs  = mask[0] && (!bnc || $urandom_range(0, 1) == 1);
                b_clr = mask[1] && (!bnc || $urandom_range(0, 1) == 1);
                b_lap = mask[2] && (!bnc || $urandom_range(0, 1) == 1);
                cyc();
            end
            b_rs = 0; b_clr = 0; b_lap = 0;
            repeat ($urandom_range(1, 40)) cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning input clock frequency.
REQ-002 SHALL have parameter TICK_HZ, default 10, meaning count increment rate.
REQ-003 SHALL have parameter DEBOUNCE_MS, default 20, meaning button stable time; DEBOUNCE_CYC = (CLK_HZ/1000)*DEBOUNCE_MS.
REQ-004 SHALL have port i_clk, input, 1, sole clock.
REQ-005 SHALL have port i_reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port i_btnRunStop, input, 1, raw asynchronous run/stop button, active-high.
REQ-007 SHALL have port i_btnClear, input, 1, raw asynchronous clear button, active-high.
REQ-008 SHALL have port i_btnLap, input, 1, raw asynchronous lap button; always present.
REQ-009 SHALL have port o_value, output, 14, displayed count 0..9999 for the digit-split stage.
REQ-010 SHALL have port o_running, output, 1, high while in RUN or LAP.
REQ-011 SHALL have port o_tick, output, 1, one-cycle pulse on each internal count increment.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYC consecutive cycles of differing synchronized input.
REQ-013 A press event SHALL be a one-cycle pulse on the debounced rising edge; release SHALL generate no event.
REQ-014 Press-to-event latency SHALL be exactly 2 + DEBOUNCE_CYC + 1 cycles from the first stable raw-high cycle.
REQ-015 The FSM SHALL have states STOP, RUN and LAP.
REQ-016 Transitions: STOP --runstop--> RUN; RUN --runstop--> STOP; RUN --lap--> LAP; LAP --lap--> RUN; LAP --runstop--> STOP.
REQ-017 The prescaler SHALL be held at 0 in STOP, SHALL count in RUN and LAP, and SHALL assert o_tick when it reaches CLK_HZ/TICK_HZ - 1, then wrap to 0.
REQ-018 The first tick after entering RUN from STOP SHALL occur exactly CLK_HZ/TICK_HZ cycles after the transition cycle.
REQ-019 On each tick, the internal count SHALL increment by 1; 9999 SHALL wrap to 0.
REQ-020 A clear event SHALL zero the count only in STOP; in RUN and LAP it SHALL be ignored.
REQ-021 A clear and a runstop event in the same STOP cycle SHALL zero the count and enter RUN, with counting starting from 0.
REQ-022 Runstop and lap events in the same cycle SHALL resolve with runstop taking priority and the lap event dropped.
REQ-023 o_value SHALL equal the internal count in STOP and RUN.
REQ-024 In LAP, o_value SHALL equal the count latched on LAP entry, while the internal count continues.
REQ-025 LAP --runstop--> STOP SHALL show the live count on the next cycle.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 i_reset SHALL, on the clock edge, force state STOP, count 0, prescaler 0, lap latch 0, debounced levels 0 and synchronizers 0.
REQ-028 After reset: o_value=0, o_running=0, o_tick=0.
REQ-029 Reset mid-press SHALL discard the press; a still-held button SHALL produce an event only after its full debounce completes.

Configuration
REQ-030 Macro STOPWATCH_LAP_EN SHALL, when defined, compile in the LAP state, lap latch and lap debouncer.
REQ-031 Without STOPWATCH_LAP_EN, i_btnLap SHALL be ignored, LAP SHALL be unreachable, and o_value SHALL always equal the internal count.

Structure
REQ-032 Shared package stopwatch_pkg SHALL hold the state enum (STOP/RUN/LAP), VALUE_W=14 and MAX_COUNT=9999.
REQ-033 Sub-module btn_debounce (synchronizer + debounce + rising-edge pulse) SHALL be instantiated once per button.

Verification
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (10-cycle tick), DEBOUNCE_MS=4 (DEBOUNCE_CYC=4).
REQ-034 Reset, then hold runstop for 8 cycles -> event at cycle 7; o_running=1; o_tick every 10 cycles; o_value 0->1 at 10 cycles after the transition.
REQ-035 Runstop high 2 cycles, low 2 cycles, repeated (bounce) -> no event, o_running stays 0.
REQ-036 Preload count 9998 in RUN, 2 ticks -> o_value 9999 then 0.
REQ-037 Clear while RUN at 37 -> count continues 38; stop, then clear -> o_value=0; clear and runstop in the same cycle -> RUN from 0.
REQ-038 With STOPWATCH_LAP_EN: lap at 25 -> o_value frozen at 25 over 5 ticks; lap again -> o_value=30.
REQ-039 Without STOPWATCH_LAP_EN, the same stimulus -> o_value tracks the count.
REQ-040 Assert i_reset mid-RUN at 412 -> next cycle o_value=0, o_running=0.
